// File: rtl/lsram_march_pkg.sv
// Shared types and per-element constant tables for the LSRAM March C- tester.
package lsram_march_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // March element index (M0..M5)
  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_FIRST = 3'd0;
  localparam elem_t ELEM_LAST  = 3'd5;

  // Per-element tables, bit N describes element MN. Bits 6 and 7 are unused
  // so that a 3-bit element index always selects a defined bit.
  //   M0 up   w0
  //   M1 up   r0 w1
  //   M2 up   r1 w0
  //   M3 down r0 w1
  //   M4 down r1 w0
  //   M5 up   r0
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;  // address walks DEPTH-1 -> 0
  localparam logic [7:0] ELEM_EXP_ONE = 8'b0001_0100;  // read expects background "1"
  localparam logic [7:0] ELEM_WR_ONE  = 8'b0000_1010;  // write stores background "1"
  localparam logic [7:0] ELEM_HAS_WR  = 8'b0001_1111;  // element contains a write

  // Picks background "0" or background "1" for a given pattern.
  function automatic logic [31:0] bg_sel32(input logic one, input logic [31:0] pat);
    return one ? ~pat : pat;
  endfunction

endpackage

// File: rtl/lsram_march_addr_gen.sv
// Up/down address counter for the march sequencer. Loads 0 or DEPTH-1 and
// flags the terminal address of the current direction by explicit compare.
module lsram_march_addr_gen #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              term_o
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next address: a load wins over a step
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? ADDR_LAST : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end
  end

  // Address register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign term_o = down_i ? (addr_q == '0) : (addr_q == ADDR_LAST);

endmodule

// File: rtl/lsram_march_tester.sv
// March C- BIST initiator for the 1024x20 dual-port LSRAM. Writes on port A,
// reads on port B, checks every read and reports pass/fail plus the first
// failing address, data and element.
module lsram_march_tester
  import lsram_march_pkg::*;
#(
  parameter int               DEPTH    = 1024,
  parameter int               ADDR_W   = 10,
  parameter int               WIDTH    = 20,
  parameter logic [WIDTH-1:0] PATTERN  = '0,
  // Count loaded when a run is accepted. Leave at 0 in normal use; a value
  // just below 16'hFFFF makes the saturating counter reachable in a short run.
  parameter logic [15:0]      ERR_INIT = 16'h0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [15:0]       ERR_COUNT,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [WIDTH-1:0]  FAIL_DATA,
  output logic [2:0]        FAIL_ELEM,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [WIDTH-1:0]  A_DIN,
  output logic              A_WEN,
  output logic [ADDR_W-1:0] B_ADDR,
  output logic [WIDTH-1:0]  B_DIN,
  output logic              B_WEN,
  input  logic [WIDTH-1:0]  B_DOUT
);

  // Saturating increment for the mismatch counter
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  state_e state_q, state_d;
  elem_t  elem_q, elem_d, elem_nxt;

  logic              ag_load, ag_load_down, ag_step, ag_down;
  logic [ADDR_W-1:0] addr;
  logic              term;

  logic [WIDTH-1:0]  exp_val, wr_val;
  logic              start_acc, mismatch;

  logic [15:0]       err_q, err_d;
  logic              fail_seen_q, fail_seen_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0]  fail_data_q, fail_data_d;
  elem_t             fail_elem_q, fail_elem_d;
  logic              pass_q, pass_d;

  assign elem_nxt = elem_q + 3'd1;
  assign ag_down  = ELEM_DOWN[elem_q];

  lsram_march_addr_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .CLK         (CLK),
    .RESET       (RESET),
    .load_i      (ag_load),
    .load_down_i (ag_load_down),
    .step_i      (ag_step),
    .down_i      (ag_down),
    .addr_o      (addr),
    .term_o      (term)
  );

  // State and element registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      elem_q  <= ELEM_FIRST;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
    end
  end

  // Next state, element advance and address-counter control
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d      = ST_WR;
          elem_d       = ELEM_FIRST;
          ag_load      = 1'b1;
          ag_load_down = ELEM_DOWN[ELEM_FIRST];
        end
      end
      ST_WR: begin
        if (term) begin
          state_d      = ST_RD;
          elem_d       = elem_nxt;
          ag_load      = 1'b1;
          ag_load_down = ELEM_DOWN[elem_nxt];
        end else begin
          ag_step = 1'b1;
        end
      end
      ST_RD: begin
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (term) begin
          if (elem_q == ELEM_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d      = ST_RD;
            elem_d       = elem_nxt;
            ag_load      = 1'b1;
            ag_load_down = ELEM_DOWN[elem_nxt];
          end
        end else begin
          state_d = ST_RD;
          ag_step = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // SRAM port drive and status strobes; everything rests at 0 in IDLE
  always_comb begin
    BUSY   = 1'b0;
    DONE   = 1'b0;
    A_WEN  = 1'b0;
    A_ADDR = '0;
    A_DIN  = '0;
    B_ADDR = '0;
    case (state_q)
      ST_WR: begin
        BUSY   = 1'b1;
        A_WEN  = 1'b1;
        A_ADDR = addr;
        A_DIN  = PATTERN;
      end
      ST_RD: begin
        BUSY   = 1'b1;
        B_ADDR = addr;
      end
      ST_CHK: begin
        // The write lands one cycle after the read of the same address
        BUSY = 1'b1;
        if (ELEM_HAS_WR[elem_q]) begin
          A_WEN  = 1'b1;
          A_ADDR = addr;
          A_DIN  = wr_val;
        end
      end
      ST_FIN: begin
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign B_DIN = '0;
  assign B_WEN = 1'b0;

  // Expected read value and element write value
  assign exp_val   = WIDTH'(bg_sel32(ELEM_EXP_ONE[elem_q], 32'(PATTERN)));
  assign wr_val    = WIDTH'(bg_sel32(ELEM_WR_ONE[elem_q], 32'(PATTERN)));
  assign start_acc = (state_q == ST_IDLE) && START;
  assign mismatch  = (state_q == ST_CHK) && (B_DOUT != exp_val);

  // Result bookkeeping: clear on accepted start, count and capture on mismatch
  always_comb begin
    err_d       = err_q;
    fail_seen_d = fail_seen_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    pass_d      = pass_q;
    if (start_acc) begin
      err_d       = ERR_INIT;
      fail_seen_d = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
      fail_elem_d = '0;
      pass_d      = 1'b0;
    end else if (mismatch) begin
      err_d = sat_inc(err_q);
      if (!fail_seen_q) begin
        fail_seen_d = 1'b1;
        fail_addr_d = addr;
        fail_data_d = B_DOUT;
        fail_elem_d = elem_q;
      end
    end
    if (state_q == ST_FIN) begin
      pass_d = (err_q == 16'h0000);
    end
  end

  // Result registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q       <= '0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      err_q       <= err_d;
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      pass_q      <= pass_d;
    end
  end

  // PASS is already valid in the DONE cycle and then held until the next run
  assign PASS      = (state_q == ST_FIN) ? (err_q == 16'h0000) : pass_q;
  assign ERR_COUNT = err_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_DATA = fail_data_q;
  assign FAIL_ELEM = fail_elem_q;

endmodule

// File: tb/tb_lsram_march_tester.sv
// Directed bench for lsram_march_tester with behavioural SRAM models.
// dut0: full 1024x20, PATTERN 0, selectable read faults.
// dut1: 16 words, PATTERN A5A5A, address 0 corrupted on its M2 read.
// dut1/dut2 use a 16-word RAM: 16 + 5*32 = 176 busy cycles, DONE in cycle 177.
// dut2: 16 words, PATTERN 0, address 15 reads all-ones, count preloaded to FFFE.
module tb_lsram_march_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // ---------------- dut0 ----------------
  logic        start0 = 1'b0;
  logic        busy0, done0, pass0, a_wen0, b_wen0;
  logic [15:0] err0;
  logic [9:0]  fail_addr0, a_addr0, b_addr0;
  logic [19:0] fail_data0, a_din0, b_din0, b_dout0;
  logic [2:0]  fail_elem0;
  logic [113:0] outs0;
  int          fault0 = 0;
  logic [19:0] mem0 [1024];

  assign outs0 = {busy0, done0, pass0, err0, fail_addr0, fail_data0, fail_elem0,
                  a_addr0, a_din0, a_wen0, b_addr0, b_din0, b_wen0};

  lsram_march_tester #(.DEPTH(1024), .ADDR_W(10), .WIDTH(20), .PATTERN(20'h00000)) dut0 (
    .CLK(clk), .RESET(rst), .START(start0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_COUNT(err0), .FAIL_ADDR(fail_addr0), .FAIL_DATA(fail_data0), .FAIL_ELEM(fail_elem0),
    .A_ADDR(a_addr0), .A_DIN(a_din0), .A_WEN(a_wen0),
    .B_ADDR(b_addr0), .B_DIN(b_din0), .B_WEN(b_wen0), .B_DOUT(b_dout0)
  );

  function automatic logic [19:0] corrupt0(input int mode, input logic [9:0] a, input logic [19:0] v);
    if (mode == 1 && a == 10'h155) return v | 20'h00008;
    if (mode == 2 && a == 10'h3FF) return 20'hFFFFF;
    return v;
  endfunction

  always @(posedge clk) begin
    if (a_wen0) mem0[a_addr0] <= a_din0;
    b_dout0 <= corrupt0(fault0, b_addr0, mem0[b_addr0]);
  end

  // ---------------- dut1 ----------------
  logic        start1 = 1'b0;
  logic        busy1, done1, pass1, a_wen1, b_wen1;
  logic [15:0] err1;
  logic [3:0]  fail_addr1, a_addr1, b_addr1;
  logic [19:0] fail_data1, a_din1, b_din1, b_dout1;
  logic [2:0]  fail_elem1;
  logic [95:0] outs1;
  logic [19:0] mem1 [16];
  int          rd0_cnt1 = 0;

  assign outs1 = {busy1, done1, pass1, err1, fail_addr1, fail_data1, fail_elem1,
                  a_addr1, a_din1, a_wen1, b_addr1, b_din1, b_wen1};

  lsram_march_tester #(.DEPTH(16), .ADDR_W(4), .WIDTH(20), .PATTERN(20'hA5A5A)) dut1 (
    .CLK(clk), .RESET(rst), .START(start1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_COUNT(err1), .FAIL_ADDR(fail_addr1), .FAIL_DATA(fail_data1), .FAIL_ELEM(fail_elem1),
    .A_ADDR(a_addr1), .A_DIN(a_din1), .A_WEN(a_wen1),
    .B_ADDR(b_addr1), .B_DIN(b_din1), .B_WEN(b_wen1), .B_DOUT(b_dout1)
  );

  // Second read of address 0 in a run is the M2 read; M2 expects ~A5A5A = 5A5A5,
  // so returning the background value A5A5A makes it the single mismatch.
  always @(posedge clk) begin
    if (a_wen1) mem1[a_addr1] <= a_din1;
    if (start1) rd0_cnt1 <= 0;
    else if (busy1 && !a_wen1 && b_addr1 == 4'h0) rd0_cnt1 <= rd0_cnt1 + 1;
    if (busy1 && !a_wen1 && b_addr1 == 4'h0 && rd0_cnt1 == 1) b_dout1 <= 20'hA5A5A;
    else b_dout1 <= mem1[b_addr1];
  end

  // ---------------- dut2 ----------------
  logic        start2 = 1'b0;
  logic        busy2, done2, pass2, a_wen2, b_wen2;
  logic [15:0] err2;
  logic [3:0]  fail_addr2, a_addr2, b_addr2;
  logic [19:0] fail_data2, a_din2, b_din2, b_dout2;
  logic [2:0]  fail_elem2;
  logic [95:0] outs2;
  logic [19:0] mem2 [16];

  assign outs2 = {busy2, done2, pass2, err2, fail_addr2, fail_data2, fail_elem2,
                  a_addr2, a_din2, a_wen2, b_addr2, b_din2, b_wen2};

  lsram_march_tester #(.DEPTH(16), .ADDR_W(4), .WIDTH(20), .PATTERN(20'h00000),
                       .ERR_INIT(16'hFFFE)) dut2 (
    .CLK(clk), .RESET(rst), .START(start2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_COUNT(err2), .FAIL_ADDR(fail_addr2), .FAIL_DATA(fail_data2), .FAIL_ELEM(fail_elem2),
    .A_ADDR(a_addr2), .A_DIN(a_din2), .A_WEN(a_wen2),
    .B_ADDR(b_addr2), .B_DIN(b_din2), .B_WEN(b_wen2), .B_DOUT(b_dout2)
  );

  always @(posedge clk) begin
    if (a_wen2) mem2[a_addr2] <= a_din2;
    b_dout2 <= (b_addr2 == 4'hF) ? 20'hFFFFF : mem2[b_addr2];
  end

  // Full dut0 run from a START sampled at edge 0; returns at the negedge of
  // the DONE cycle (or after the cycle bound) with observations collected.
  task automatic run0(output int done_cyc, output int m0_ok, output int busy_cnt,
                      output logic [9:0] m3_addr, output logic m3_wr_ok);
    done_cyc = -1; m0_ok = 0; busy_cnt = 0; m3_addr = 10'h000; m3_wr_ok = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 12000 && done_cyc < 0; n++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (busy0) busy_cnt++;
      if (n <= 1024 && busy0 && a_wen0 && a_addr0 == 10'(n - 1) && a_din0 == 20'h00000) m0_ok++;
      if (n == 5121 && !a_wen0) m3_addr = b_addr0;
      if (n == 5122) m3_wr_ok = a_wen0 && a_addr0 == 10'h3FF && a_din0 == 20'hFFFFF;
      if (done0) done_cyc = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (outs0 !== '0) begin bad++; $display("FAIL reset_dut0 got %h want 0", outs0); end
    total++; if (outs1 !== '0) begin bad++; $display("FAIL reset_dut1 got %h want 0", outs1); end
    total++; if (outs2 !== '0) begin bad++; $display("FAIL reset_dut2 got %h want 0", outs2); end
    rst = 1'b0;
  endtask

  task automatic test_fault_free();
    int dc, m0, bc; logic [9:0] m3a; logic m3w;
    fault0 = 0;
    run0(dc, m0, bc, m3a, m3w);
    total++; if (dc !== 11265) begin bad++; $display("FAIL ff_done_cycle got %0d want 11265", dc); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL ff_pass got %b want 1", pass0); end
    total++; if (err0 !== 16'h0) begin bad++; $display("FAIL ff_err got %h want 0000", err0); end
    total++; if (m0 !== 1024) begin bad++; $display("FAIL ff_m0_writes got %0d want 1024", m0); end
    total++; if (bc !== 11264) begin bad++; $display("FAIL ff_busy_cycles got %0d want 11264", bc); end
    total++; if (m3a !== 10'h3FF) begin bad++; $display("FAIL ff_m3_first_read got %h want 3ff", m3a); end
    total++; if (m3w !== 1'b1) begin bad++; $display("FAIL ff_m3_first_write got %b want 1", m3w); end
    @(negedge clk);
    total++; if ({done0, busy0, pass0} !== 3'b001) begin
      bad++; $display("FAIL ff_pass_hold got done/busy/pass=%b want 001", {done0, busy0, pass0});
    end
  endtask

  task automatic test_stuck_bit();
    int dc, m0, bc; logic [9:0] m3a; logic m3w;
    fault0 = 1;
    run0(dc, m0, bc, m3a, m3w);
    fault0 = 0;
    total++; if (dc !== 11265) begin bad++; $display("FAIL sb_done_cycle got %0d want 11265", dc); end
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL sb_pass got %b want 0", pass0); end
    total++; if (err0 !== 16'd3) begin bad++; $display("FAIL sb_err got %h want 0003", err0); end
    total++; if (fail_addr0 !== 10'h155) begin bad++; $display("FAIL sb_fail_addr got %h want 155", fail_addr0); end
    total++; if (fail_data0 !== 20'h00008) begin bad++; $display("FAIL sb_fail_data got %h want 00008", fail_data0); end
    total++; if (fail_elem0 !== 3'd1) begin bad++; $display("FAIL sb_fail_elem got %0d want 1", fail_elem0); end
  endtask

  task automatic test_pattern_m2();
    int dc = -1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 400 && dc < 0; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) dc = n;
    end
    total++; if (dc !== 177) begin bad++; $display("FAIL pat_done_cycle got %0d want 177", dc); end
    total++; if (err1 !== 16'd1) begin bad++; $display("FAIL pat_err got %h want 0001", err1); end
    total++; if (fail_elem1 !== 3'd2) begin bad++; $display("FAIL pat_fail_elem got %0d want 2", fail_elem1); end
    total++; if (fail_data1 !== 20'hA5A5A) begin bad++; $display("FAIL pat_fail_data got %h want a5a5a", fail_data1); end
    total++; if (fail_addr1 !== 4'h0) begin bad++; $display("FAIL pat_fail_addr got %h want 0", fail_addr1); end
    total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL pat_pass got %b want 0", pass1); end
  endtask

  task automatic test_start_ignored();
    int dc = -1;
    int starts_seen = 0;
    fault0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 12000 && dc < 0; n++) begin
      @(negedge clk);
      // high for the edges at cycles 100 and 11000, both while BUSY
      start0 = (n == 99) || (n == 10999);
      if (n > 1 && busy0 && a_wen0 && a_addr0 == 10'h000 && n < 1025 && n != 1) starts_seen++;
      if (done0) dc = n;
    end
    start0 = 1'b0;
    total++; if (dc !== 11265) begin bad++; $display("FAIL st_done_cycle got %0d want 11265", dc); end
    total++; if (starts_seen !== 0) begin bad++; $display("FAIL st_restart_in_m0 got %0d want 0", starts_seen); end
    @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL st_idle_11266 got %b want 0", busy0); end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    total++; if ({busy0, a_wen0, a_addr0} !== {2'b11, 10'h000}) begin
      bad++; $display("FAIL st_new_run got busy/wen/addr=%b/%b/%h want 1/1/000", busy0, a_wen0, a_addr0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int dc, m0, bc, stray; logic [9:0] m3a; logic m3w;
    stray = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 500; n++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    total++; if (a_wen0 !== 1'b1) begin bad++; $display("FAIL rm_busy_before got %b want 1", a_wen0); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (outs0 !== '0) begin bad++; $display("FAIL rm_outputs_501 got %h want 0", outs0); end
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done0 || busy0 || a_wen0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rm_no_done got %0d want 0", stray); end
    run0(dc, m0, bc, m3a, m3w);
    total++; if (dc !== 11265) begin bad++; $display("FAIL rm_rerun_done got %0d want 11265", dc); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL rm_rerun_pass got %b want 1", pass0); end
  endtask

  task automatic test_stuck_word();
    int dc, m0, bc; logic [9:0] m3a; logic m3w;
    fault0 = 2;
    run0(dc, m0, bc, m3a, m3w);
    fault0 = 0;
    total++; if (err0 !== 16'd3) begin bad++; $display("FAIL sw_err got %h want 0003", err0); end
    total++; if (fail_addr0 !== 10'h3FF) begin bad++; $display("FAIL sw_fail_addr got %h want 3ff", fail_addr0); end
    total++; if (fail_data0 !== 20'hFFFFF) begin bad++; $display("FAIL sw_fail_data got %h want fffff", fail_data0); end
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL sw_pass got %b want 0", pass0); end
  endtask

  task automatic test_saturation();
    int dc = -1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 400 && dc < 0; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) dc = n;
    end
    total++; if (dc !== 177) begin bad++; $display("FAIL sat_done_cycle got %0d want 177", dc); end
    total++; if (err2 !== 16'hFFFF) begin bad++; $display("FAIL sat_err got %h want ffff", err2); end
    total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL sat_pass got %b want 0", pass2); end
    total++; if ({fail_elem2, fail_addr2, fail_data2} !== {3'd1, 4'hF, 20'hFFFFF}) begin
      bad++; $display("FAIL sat_capture got elem/addr/data=%0d/%h/%h want 1/f/fffff", fail_elem2, fail_addr2, fail_data2);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_pattern_m2();
    test_start_ignored();
    test_reset_midrun();
    test_stuck_word();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
